// File: rtl/mac_result_collector_pkg.sv
// Shared MAC result definitions: precision mode encodings, lane geometry and FSM states.
// Also imported by the MAC engine so both ends agree on the packing.
package mac_result_collector_pkg;

    typedef enum logic [1:0] {
        MODE_2B      = 2'b00,
        MODE_4B      = 2'b01,
        MODE_8B      = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_e;

    localparam int unsigned DATA_W    = 128;
    localparam int unsigned LANE_W_2B = 8;
    localparam int unsigned LANE_W_4B = 12;
    localparam int unsigned LANE_W_8B = 20;
    localparam int unsigned LANES_2B  = 16;
    localparam int unsigned LANES_4B  = 4;
    localparam int unsigned LANES_8B  = 1;

    // Index of the final lane of a word; the illegal mode is treated as single-lane.
    function automatic logic [3:0] last_lane(input mode_e m);
        case (m)
            MODE_2B: last_lane = 4'(LANES_2B - 1);
            MODE_4B: last_lane = 4'(LANES_4B - 1);
            default: last_lane = 4'(LANES_8B - 1);
        endcase
    endfunction

endpackage

// File: rtl/mac_result_collector_lane_extract.sv
// lane_extract: selects one lane from the held result word and sign-extends it to OUT_W.
// With MAC_COLLECTOR_RELU_EN defined, negative lanes are clamped to zero.
module lane_extract
    import mac_result_collector_pkg::*;
#(
    parameter int unsigned OUT_W = 32
) (
    input  logic [DATA_W-1:0] hold_i,
    input  mode_e             mode_i,
    input  logic [3:0]        lane_i,
    output logic [OUT_W-1:0]  data_o
);

    logic [6:0]                  base12;
    logic signed [LANE_W_2B-1:0] lane8;
    logic signed [LANE_W_4B-1:0] lane12;
    logic signed [LANE_W_8B-1:0] lane20;

    always_comb begin
        // 12*lane built as 8*lane + 4*lane to keep the select index 7 bits wide
        base12 = {2'b00, lane_i[1:0], 3'b000} + {3'b000, lane_i[1:0], 2'b00};
        lane8  = hold_i[{lane_i, 3'b000} +: LANE_W_2B];
        lane12 = hold_i[base12 +: LANE_W_4B];
        lane20 = '0;
        case (mode_i)
            MODE_2B: lane20 = LANE_W_8B'(lane8);
            MODE_4B: lane20 = LANE_W_8B'(lane12);
            MODE_8B: lane20 = hold_i[LANE_W_8B-1:0];
            default: lane20 = '0;
        endcase
        data_o = OUT_W'(lane20);
`ifdef MAC_COLLECTOR_RELU_EN
        if (lane20[LANE_W_8B-1]) begin
            data_o = '0;
        end
`endif
    end

endmodule

// File: rtl/mac_result_collector.sv
// mac_result_collector: accepts 128-bit MAC result words and streams them out one lane per cycle.
// Optional ReLU clamping of negative lanes is enabled by defining MAC_COLLECTOR_RELU_EN.
module mac_result_collector
    import mac_result_collector_pkg::*;
#(
    parameter int unsigned OUT_W = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [3:0]        out_lane,
    output logic              out_last,
    output logic [CNT_W-1:0]  result_count,
    output logic              mode_err
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    mode_e              mode_q, mode_d;
    logic [3:0]         lane_q, lane_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            mode_q  <= MODE_8B;
            lane_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            lane_q  <= lane_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        mode_d    = mode_q;
        lane_d    = lane_q;
        count_d   = count_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hold_d = in_data;
                    mode_d = mode_e'(mode);
                    lane_d = '0;
                    // Illegal words are latched but never drained or counted
                    if (mode_e'(mode) == MODE_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (out_last) begin
                        state_d = S_IDLE;
                    end else begin
                        lane_d = lane_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_lane     = lane_q;
    assign out_last     = (lane_q == last_lane(mode_q));
    assign result_count = count_q;
    assign mode_err     = err_q;

    lane_extract #(
        .OUT_W(OUT_W)
    ) u_lane_extract (
        .hold_i (hold_q),
        .mode_i (mode_q),
        .lane_i (lane_q),
        .data_o (out_data)
    );

endmodule

// File: tb/tb_mac_result_collector.sv
// Self-checking bench for mac_result_collector: queue-based reference model checked every cycle,
// plus directed literal checks from the test plan and a randomized phase.
module tb_mac_result_collector;

    localparam int CNT_W = 4;
`ifdef MAC_COLLECTOR_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             nrst;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [3:0]       out_lane;
    logic             out_last;
    logic [CNT_W-1:0] result_count;
    logic             mode_err;

    mac_result_collector #(
        .OUT_W(32),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .mode         (mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_lane     (out_lane),
        .out_last     (out_last),
        .result_count (result_count),
        .mode_err     (mode_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  lane;
        logic        last;
    } lane_t;

    lane_t       q[$];
    int unsigned m_count = 0;
    bit          m_err   = 1'b0;
    bit          live    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane value from plain arithmetic: take w bits at offset w*i, interpret as two's complement.
    function automatic logic [31:0] model_lane(input logic [127:0] d, input int unsigned w, input int unsigned i);
        logic [127:0] sh;
        longint       raw;
        longint       v;
        sh  = d >> (w * i);
        raw = longint'(sh[31:0]) & ((longint'(1) << w) - 1);
        v   = (raw >= (longint'(1) << (w - 1))) ? raw - (longint'(1) << w) : raw;
        if (RELU && v < 0) v = 0;
        return v[31:0];
    endfunction

    always @(posedge clk) begin
        if (!nrst) begin
            q.delete();
            m_count = 0;
            m_err   = 1'b0;
        end else if (q.size() == 0) begin
            if (in_valid) begin
                int unsigned w;
                int unsigned n;
                if (mode == 2'b11) begin
                    m_err = 1'b1;
                end else begin
                    w = (mode == 2'b00) ? 8 : (mode == 2'b01) ? 12 : 20;
                    n = (mode == 2'b00) ? 16 : (mode == 2'b01) ? 4 : 1;
                    for (int unsigned i = 0; i < n; i++)
                        q.push_back('{model_lane(in_data, w, i), 4'(i), (i == n - 1)});
                    m_count = (m_count + 1) % (1 << CNT_W);
                end
            end
        end else if (out_ready) begin
            void'(q.pop_front());
        end
        live = 1'b1;
    end

    always @(negedge clk) begin
        if (live) begin
            check("m_in_ready", {31'b0, in_ready}, {31'b0, q.size() == 0});
            check("m_out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            check("m_count", 32'(result_count), m_count);
            check("m_mode_err", {31'b0, mode_err}, {31'b0, m_err});
            if (q.size() != 0) begin
                check("m_out_data", out_data, q[0].data);
                check("m_out_lane", 32'(out_lane), 32'(q[0].lane));
                check("m_out_last", {31'b0, out_last}, {31'b0, q[0].last});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] d, input logic [1:0] m);
        in_data  = d;
        mode     = m;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        logic [31:0]  e4[4];

        nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; mode = 2'b00;
        repeat (2) cyc();
        nrst = 1'b1;
        cyc();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_lane", 32'(out_lane), 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd1);
        check("rst_count", 32'(result_count), 32'd0);
        check("rst_mode_err", {31'b0, mode_err}, 32'd0);

        // 8b word
        out_ready = 1'b1;
        d = {$urandom, $urandom, $urandom, $urandom};
        d[19:0] = 20'hFFFFF;
        accept(d, 2'b10);
        check("b8_valid", {31'b0, out_valid}, 32'd1);
        check("b8_data", out_data, RELU ? 32'h0 : 32'hFFFFFFFF);
        check("b8_lane", 32'(out_lane), 32'd0);
        check("b8_last", {31'b0, out_last}, 32'd1);
        check("b8_count", 32'(result_count), 32'd1);
        cyc();
        check("b8_in_ready", {31'b0, in_ready}, 32'd1);

        // 4b word
        d = {$urandom, $urandom, $urandom, $urandom};
        d[47:0] = {12'h000, 12'h001, 12'h800, 12'h7FF};
        e4 = '{32'h000007FF, RELU ? 32'h0 : 32'hFFFFF800, 32'h1, 32'h0};
        accept(d, 2'b01);
        for (int i = 0; i < 4; i++) begin
            check("b4_data", out_data, e4[i]);
            check("b4_lane", 32'(out_lane), 32'(i));
            check("b4_last", {31'b0, out_last}, {31'b0, i == 3});
            cyc();
        end
        check("b4_in_ready", {31'b0, in_ready}, 32'd1);

        // 2b word with a stall at lane 5
        d = '0;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'h80 + 8'(i);
        accept(d, 2'b00);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                out_ready = 1'b0;
                repeat (3) begin
                    cyc();
                    check("b2_stall_lane", 32'(out_lane), 32'd5);
                    check("b2_stall_data", out_data, RELU ? 32'h0 : 32'hFFFFFF85);
                end
                out_ready = 1'b1;
            end
            check("b2_lane", 32'(out_lane), 32'(i));
            check("b2_data", out_data, RELU ? 32'h0 : {24'hFFFFFF, 8'h80 + 8'(i)});
            cyc();
        end
        check("b2_count", 32'(result_count), 32'd3);

        // Illegal mode, then a legal word
        accept({$urandom, $urandom, $urandom, $urandom}, 2'b11);
        check("ill_err", {31'b0, mode_err}, 32'd1);
        check("ill_valid", {31'b0, out_valid}, 32'd0);
        check("ill_count", 32'(result_count), 32'd3);
        d = '0;
        d[19:0] = 20'h00123;
        accept(d, 2'b10);
        check("ill_next_data", out_data, 32'h00000123);
        check("ill_next_err", {31'b0, mode_err}, 32'd1);
        check("ill_next_count", 32'(result_count), 32'd4);
        cyc();

        // Reset in the middle of a 2b drain
        accept({$urandom, $urandom, $urandom, $urandom}, 2'b00);
        repeat (7) cyc();
        check("mid_lane7", 32'(out_lane), 32'd7);
        nrst = 1'b0;
        cyc();
        nrst = 1'b1;
        check("mid_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_count", 32'(result_count), 32'd0);
        check("mid_err", {31'b0, mode_err}, 32'd0);
        check("mid_lane", 32'(out_lane), 32'd0);
        check("mid_last", {31'b0, out_last}, 32'd1);
        check("mid_data", out_data, 32'd0);

        // Negative and positive 4b lanes
        d = '0;
        d[23:0] = {12'h005, 12'hFFF};
        accept(d, 2'b01);
        check("relu_l0", out_data, RELU ? 32'h0 : 32'hFFFFFFFF);
        cyc();
        check("relu_l1", out_data, 32'h5);
        repeat (3) cyc();

        // Randomized traffic; upstream holds its word while the collector is busy
        for (int c = 0; c < 4000; c++) begin
            if (!(in_valid && q.size() != 0)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                mode     = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 9) < 7);
            nrst      = ($urandom_range(0, 799) != 0);
            cyc();
        end
        nrst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
